// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// The carry chain is split into STAGES register slices; each slice resolves WIDTH/STAGES result bits.
module cla_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NGRP = WIDTH / GROUP;
  localparam int GPS  = NGRP / STAGES;
  localparam int SW   = GPS * GROUP;

  // Carries c[0..GROUP] of one group, each a flat OR of generate/propagate products.
  function automatic logic [GROUP:0] group_carries(input logic [GROUP-1:0] ga,
                                                   input logic [GROUP-1:0] gb,
                                                   input logic             c0);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = {(GROUP+1){1'b0}};
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = c0;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic [STAGES-1:0] carry_q;
  logic              ovf_q;
  logic              zero_q;

  logic [WIDTH-1:0]  a_d     [STAGES];
  logic [WIDTH-1:0]  b_d     [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic [STAGES-1:0] carry_d;
  logic              ovf_d;
  logic              zero_d;

  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] en_s;
  logic [STAGES-1:0] src_v_s;

  // Each slice works on what the slice below registered; slice 0 works on the live operands.
  always_comb begin : p_slices
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             sc;
    logic             cmsb;
    logic [GROUP:0]   gc;
    int               base;
    int               prv;
    sa   = {WIDTH{1'b0}};
    sb   = {WIDTH{1'b0}};
    ss   = {WIDTH{1'b0}};
    sc   = 1'b0;
    cmsb = 1'b0;
    gc   = {(GROUP+1){1'b0}};
    base = 0;
    prv  = 0;
    for (int k = 0; k < STAGES; k++) begin
      prv = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        sa = a;
        sb = b ^ {WIDTH{sub}};
        ss = {WIDTH{1'b0}};
        sc = sub | cin;
      end else begin
        sa = a_q[prv];
        sb = b_q[prv];
        ss = sum_q[prv];
        sc = carry_q[prv];
      end
      cmsb = 1'b0;
      for (int gi = 0; gi < GPS; gi++) begin
        base = k * SW + gi * GROUP;
        gc   = group_carries(sa[base +: GROUP], sb[base +: GROUP], sc);
        ss[base +: GROUP] = sa[base +: GROUP] ^ sb[base +: GROUP] ^ gc[GROUP-1:0];
        cmsb = (base + GROUP == WIDTH) ? gc[GROUP-1] : cmsb;
        sc   = gc[GROUP];
      end
      a_d[k]     = sa;
      b_d[k]     = sb;
      sum_d[k]   = ss;
      carry_d[k] = sc;
    end
    // Locals now hold the last slice, i.e. the complete result.
    ovf_d  = cmsb ^ sc;
    zero_d = ~|ss;
  end

  // Backpressure resolved from the output end down, so a full pipe still accepts while draining.
  always_comb begin : p_flow
    int nxt;
    int prv;
    adv_s   = {STAGES{1'b0}};
    en_s    = {STAGES{1'b0}};
    src_v_s = {STAGES{1'b0}};
    nxt     = 0;
    prv     = 0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      nxt = (k == STAGES - 1) ? k : k + 1;
      prv = (k == 0) ? k : k - 1;
      if (k == STAGES - 1) begin
        adv_s[k] = valid_q[k] & out_ready;
      end else begin
        adv_s[k] = valid_q[k] & (~valid_q[nxt] | adv_s[nxt]);
      end
      en_s[k]    = ~valid_q[k] | adv_s[k];
      src_v_s[k] = (k == 0) ? in_valid : valid_q[prv];
    end
  end

  // Slice registers load whenever the slice is empty or its contents move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {STAGES{1'b0}};
      carry_q <= {STAGES{1'b0}};
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        sum_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en_s[k]) begin
          valid_q[k] <= src_v_s[k];
          if (src_v_s[k]) begin
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
      if (en_s[STAGES-1] && src_v_s[STAGES-1]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign in_ready  = en_s[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
